riscv_alu_issue: RTL

// - RV32I decode/issue stage driving the ALU: takes fetched instr + register-file operands,

---
 rtl/riscv_alu_issue.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/riscv_alu_issue.sv
// RV32I decode/issue stage feeding the ALU.
// One registered output slot plus a one-entry skid buffer.
module riscv_alu_issue #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [31:0]      in_pc,
  input  logic [31:0]      in_rs1_data,
  input  logic [31:0]      in_rs2_data,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_a,
  output logic [31:0]      out_b,
  output logic [3:0]       out_alu_ctrl,
  output logic [4:0]       out_rd,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [3:0] ADD  = 4'd0;
  localparam logic [3:0] SUB  = 4'd1;
  localparam logic [3:0] AND  = 4'd2;
  localparam logic [3:0] OR   = 4'd3;
  localparam logic [3:0] XOR  = 4'd4;
  localparam logic [3:0] SLL  = 4'd5;
  localparam logic [3:0] SRL  = 4'd6;
  localparam logic [3:0] SRA  = 4'd7;
  localparam logic [3:0] SLT  = 4'd8;
  localparam logic [3:0] SLTU = 4'd9;

  localparam logic [6:0] OP_REG = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_AUI = 7'b0010111;

  typedef struct packed {
    logic [31:0]      a;
    logic [31:0]      b;
    logic [3:0]       ctrl;
    logic [4:0]       rd;
    logic             ill;
    logic [TAG_W-1:0] tag;
  } ent_t;

  function automatic logic [3:0] f3_ctrl(
    input logic [2:0] f3,
    input logic       alt
  );
    logic [3:0] c;
    unique case (f3)
      3'b000:  c = alt ? SUB : ADD;
      3'b001:  c = SLL;
      3'b010:  c = SLT;
      3'b011:  c = SLTU;
      3'b100:  c = XOR;
      3'b101:  c = alt ? SRA : SRL;
      3'b110:  c = OR;
      default: c = AND;
    endcase
    return c;
  endfunction

  logic [6:0]  w_op;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic        w_alt;
  logic        w_f7z;
  logic [31:0] w_imm;
  logic [31:0] w_shamt;
  logic [31:0] w_uimm;
  ent_t        w_dec;

  assign w_op    = in_instr[6:0];
  assign w_f3    = in_instr[14:12];
  assign w_f7    = in_instr[31:25];
  assign w_alt   = (w_f7 == 7'b0100000);
  assign w_f7z   = (w_f7 == 7'b0000000);
  assign w_imm   = {{20{in_instr[31]}}, in_instr[31:20]};
  assign w_shamt = {27'b0, in_instr[24:20]};
  assign w_uimm  = {in_instr[31:12], 12'b0};

  // Illegal encodings issue as ADD 0,0 so the ALU sees a harmless op.
  always_comb begin
    w_dec     = '0;
    w_dec.rd  = in_instr[11:7];
    w_dec.tag = in_tag;
    w_dec.ill = 1'b1;
    unique case (w_op)
      OP_REG: begin
        if (w_f7z || (w_alt && (w_f3 == 3'b000 || w_f3 == 3'b101))) begin
          w_dec.a    = in_rs1_data;
          w_dec.b    = in_rs2_data;
          w_dec.ctrl = f3_ctrl(w_f3, w_alt);
          w_dec.ill  = 1'b0;
        end
      end
      OP_IMM: begin
        if (w_f3 == 3'b001) begin
          if (w_f7z) begin
            w_dec.a    = in_rs1_data;
            w_dec.b    = w_shamt;
            w_dec.ctrl = SLL;
            w_dec.ill  = 1'b0;
          end
        end else if (w_f3 == 3'b101) begin
          if (w_f7z || w_alt) begin
            w_dec.a    = in_rs1_data;
            w_dec.b    = w_shamt;
            w_dec.ctrl = w_alt ? SRA : SRL;
            w_dec.ill  = 1'b0;
          end
        end else begin
          w_dec.a    = in_rs1_data;
          w_dec.b    = w_imm;
          w_dec.ctrl = f3_ctrl(w_f3, 1'b0);
          w_dec.ill  = 1'b0;
        end
      end
      OP_LUI: begin
        w_dec.b   = w_uimm;
        w_dec.ill = 1'b0;
      end
      OP_AUI: begin
        w_dec.a   = in_pc;
        w_dec.b   = w_uimm;
        w_dec.ill = 1'b0;
      end
      default: ;
    endcase
  end

  ent_t r_out;
  ent_t r_skid;
  logic r_ov;
  logic r_sv;
  logic r_rdy;
  logic w_acc;
  logic w_drain;

  assign w_acc   = in_valid && r_rdy;
  assign w_drain = !r_ov || out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out  <= '0;
      r_skid <= '0;
      r_ov   <= 1'b0;
      r_sv   <= 1'b0;
      r_rdy  <= 1'b0;
    end else if (flush) begin
      r_ov  <= 1'b0;
      r_sv  <= 1'b0;
      r_rdy <= 1'b1;
    end else if (w_drain) begin
      if (r_sv) begin
        r_out <= r_skid;
        r_ov  <= 1'b1;
        r_sv  <= w_acc;
        r_rdy <= !w_acc;
        if (w_acc) r_skid <= w_dec;
      end else begin
        r_ov  <= w_acc;
        r_rdy <= 1'b1;
        if (w_acc) r_out <= w_dec;
      end
    end else if (w_acc) begin
      r_skid <= w_dec;
      r_sv   <= 1'b1;
      r_rdy  <= 1'b0;
    end
  end

  assign in_ready     = r_rdy;
  assign out_valid    = r_ov;
  assign out_a        = r_out.a;
  assign out_b        = r_out.b;
  assign out_alu_ctrl = r_out.ctrl;
  assign out_rd       = r_out.rd;
  assign out_illegal  = r_out.ill;
  assign out_tag      = r_out.tag;

endmodule
